// File: rtl/countdown_timer_if.sv
// Key/preset inputs and display/status outputs of the countdown timer.
// The master side drives keys and presets; the slave side is the timer.
interface countdown_timer_if;
   logic       iSTARTn;
   logic       iLOADn;
   logic [2:0] iSEL;
   logic [4:0] iDATA;
   logic [3:0] oCNT_100MS;
   logic [3:0] oCNT_1S;
   logic [2:0] oCNT_10S;
   logic [3:0] oCNT_1MIN;
   logic [2:0] oCNT_10MIN;
   logic [4:0] oCNT_1H;
   logic       oTICK;
   logic       oRUN;
   logic       oDONE;

   modport master (
      output iSTARTn, iLOADn, iSEL, iDATA,
      input  oCNT_100MS, oCNT_1S, oCNT_10S,
      input  oCNT_1MIN, oCNT_10MIN, oCNT_1H,
      input  oTICK, oRUN, oDONE
   );

   modport slave (
      input  iSTARTn, iLOADn, iSEL, iDATA,
      output oCNT_100MS, oCNT_1S, oCNT_10S,
      output oCNT_1MIN, oCNT_10MIN, oCNT_1H,
      output oTICK, oRUN, oDONE
   );
endinterface

// File: rtl/countdown_timer.sv
// H:MM:SS.t countdown timer: switch presets, 100 ms decrement,
// latched alarm when the count reaches zero.
module countdown_timer #(
   parameter int DIV = 5000000,
   parameter int PW  = 23
) (
   input  logic             iCLK,
   input  logic             iRSTn,
   countdown_timer_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_PAUSE,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // [0] first sync flop, [1] second, [2] previous synced level
   logic [2:0] r_start_sync;
   logic [2:0] r_load_sync;
   logic       r_start_ev;
   logic       r_load_ev;

   logic [PW-1:0] r_pre;

   logic [3:0] r_tenths;
   logic [3:0] r_sec1;
   logic [2:0] r_sec10;
   logic [3:0] r_min1;
   logic [2:0] r_min10;
   logic [4:0] r_hour;

   logic       w_b0, w_b1, w_b2, w_b3, w_b4;
   logic       w_zero;
   logic       w_dec_zero;
   logic [3:0] w_tenths_dec;
   logic [3:0] w_sec1_dec;
   logic [2:0] w_sec10_dec;
   logic [3:0] w_min1_dec;
   logic [2:0] w_min10_dec;
   logic [4:0] w_hour_dec;

   logic [3:0] w_dig_sat;
   logic [2:0] w_ten_sat;
   logic [4:0] w_hour_sat;
   logic       w_sel_ok;

   logic       w_start;
   logic       w_load;
   logic       w_cnt_en;
   logic       w_tick;
   logic       w_run;
   logic       w_done;

   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         r_start_sync <= 3'b111;
         r_load_sync  <= 3'b111;
         r_start_ev   <= 1'b0;
         r_load_ev    <= 1'b0;
      end else begin
         r_start_sync <= {r_start_sync[1:0], bus.iSTARTn};
         r_load_sync  <= {r_load_sync[1:0], bus.iLOADn};
         r_start_ev   <= r_start_sync[2] & ~r_start_sync[1];
         r_load_ev    <= r_load_sync[2] & ~r_load_sync[1];
      end
   end

   assign w_zero = ~|{r_tenths, r_sec1, r_sec10,
                      r_min1, r_min10, r_hour};

   assign w_b0 = (r_tenths == 4'd0);
   assign w_b1 = w_b0 && (r_sec1 == 4'd0);
   assign w_b2 = w_b1 && (r_sec10 == 3'd0);
   assign w_b3 = w_b2 && (r_min1 == 4'd0);
   assign w_b4 = w_b3 && (r_min10 == 3'd0);

   always_comb begin
      w_tenths_dec = r_tenths;
      w_sec1_dec   = r_sec1;
      w_sec10_dec  = r_sec10;
      w_min1_dec   = r_min1;
      w_min10_dec  = r_min10;
      w_hour_dec   = r_hour;
      // a zero count holds, so hours can never wrap
      if (!w_zero) begin
         w_tenths_dec = w_b0 ? 4'd9 : r_tenths - 4'd1;
         if (w_b0)
            w_sec1_dec = (r_sec1 == 4'd0) ? 4'd9 : r_sec1 - 4'd1;
         if (w_b1)
            w_sec10_dec = (r_sec10 == 3'd0) ? 3'd5 : r_sec10 - 3'd1;
         if (w_b2)
            w_min1_dec = (r_min1 == 4'd0) ? 4'd9 : r_min1 - 4'd1;
         if (w_b3)
            w_min10_dec = (r_min10 == 3'd0) ? 3'd5 : r_min10 - 3'd1;
         if (w_b4)
            w_hour_dec = r_hour - 5'd1;
      end
   end

   assign w_dec_zero = ~|{w_tenths_dec, w_sec1_dec, w_sec10_dec,
                          w_min1_dec, w_min10_dec, w_hour_dec};

   assign w_dig_sat  = (bus.iDATA[3:0] > 4'd9) ? 4'd9 : bus.iDATA[3:0];
   assign w_ten_sat  = (bus.iDATA[3:0] > 4'd5) ? 3'd5 : bus.iDATA[2:0];
   assign w_hour_sat = (bus.iDATA > 5'd23) ? 5'd23 : bus.iDATA;
   assign w_sel_ok   = (bus.iSEL <= 3'd5);

   assign w_start  = r_start_ev;
   assign w_load   = r_load_ev & ~r_start_ev & w_sel_ok
                     & (r_state != S_RUN);
   // a start event in RUN freezes the prescaler for the pause
   assign w_cnt_en = (r_state == S_RUN) & ~w_start;
   assign w_tick   = w_cnt_en & (r_pre == PW'(DIV - 1));

   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_start && !w_zero)
               w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (w_start)
               w_state_nxt = S_PAUSE;
            else if (w_tick && w_dec_zero)
               w_state_nxt = S_DONE;
         end
         S_PAUSE: begin
            if (w_start)
               w_state_nxt = S_RUN;
         end
         S_DONE: begin
            if (w_start || w_load)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_run  = 1'b0;
      w_done = 1'b0;
      unique case (r_state)
         S_RUN:   w_run  = 1'b1;
         S_DONE:  w_done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn)
         r_pre <= '0;
      else if (r_state == S_IDLE || w_load || w_tick)
         r_pre <= '0;
      else if (w_cnt_en)
         r_pre <= r_pre + PW'(1);
   end

   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         r_tenths <= 4'd0;
         r_sec1   <= 4'd0;
         r_sec10  <= 3'd0;
         r_min1   <= 4'd0;
         r_min10  <= 3'd0;
         r_hour   <= 5'd0;
      end else if (w_tick) begin
         r_tenths <= w_tenths_dec;
         r_sec1   <= w_sec1_dec;
         r_sec10  <= w_sec10_dec;
         r_min1   <= w_min1_dec;
         r_min10  <= w_min10_dec;
         r_hour   <= w_hour_dec;
      end else if (w_load) begin
         unique case (bus.iSEL)
            3'd0:    r_tenths <= w_dig_sat;
            3'd1:    r_sec1   <= w_dig_sat;
            3'd2:    r_sec10  <= w_ten_sat;
            3'd3:    r_min1   <= w_dig_sat;
            3'd4:    r_min10  <= w_ten_sat;
            3'd5:    r_hour   <= w_hour_sat;
            default: ;
         endcase
      end
   end

   assign bus.oCNT_100MS = r_tenths;
   assign bus.oCNT_1S    = r_sec1;
   assign bus.oCNT_10S   = r_sec10;
   assign bus.oCNT_1MIN  = r_min1;
   assign bus.oCNT_10MIN = r_min10;
   assign bus.oCNT_1H    = r_hour;
   assign bus.oTICK      = w_tick;
   assign bus.oRUN       = w_run;
   assign bus.oDONE      = w_done;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with a 4-cycle tick (DIV=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_countdown_timer;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   countdown_timer_if bus ();

   countdown_timer #(
      .DIV (4),
      .PW  (2)
   ) dut (
      .iCLK  (clk),
      .iRSTn (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [22:0] tv(input int h, input int m10,
                                      input int m1, input int s10,
                                      input int s1, input int t);
      return {5'(h), 3'(m10), 4'(m1), 3'(s10), 4'(s1), 4'(t)};
   endfunction

   function automatic logic [22:0] cur();
      return {bus.oCNT_1H, bus.oCNT_10MIN, bus.oCNT_1MIN,
              bus.oCNT_10S, bus.oCNT_1S, bus.oCNT_100MS};
   endfunction

   task automatic chk(input string tag, input logic [22:0] obs,
                      input logic [22:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // one-cycle key press; returns once its effect is visible
   task automatic press_start();
      bus.iSTARTn = 1'b0;
      step(1);
      bus.iSTARTn = 1'b1;
      step(3);
   endtask

   task automatic load(input int sel, input int data);
      bus.iSEL    = 3'(sel);
      bus.iDATA   = 5'(data);
      bus.iLOADn  = 1'b0;
      step(1);
      bus.iLOADn  = 1'b1;
      step(3);
   endtask

   initial begin
      tests       = 0;
      fails       = 0;
      rst_n       = 1'b0;
      bus.iSTARTn = 1'b1;
      bus.iLOADn  = 1'b1;
      bus.iSEL    = 3'd7;
      bus.iDATA   = 5'd0;
      step(3);
      chk("rst_digits", cur(), tv(0, 0, 0, 0, 0, 0));
      chk("rst_run", 23'(bus.oRUN), 23'd0);
      chk("rst_done", 23'(bus.oDONE), 23'd0);
      chk("rst_tick", 23'(bus.oTICK), 23'd0);
      rst_n = 1'b1;
      step(2);

      load(2, 9);
      chk("sat_10s", cur(), tv(0, 0, 0, 5, 0, 0));
      load(5, 30);
      chk("sat_hour", cur(), tv(23, 0, 0, 5, 0, 0));

      load(5, 1);
      load(2, 0);
      chk("load_1h", cur(), tv(1, 0, 0, 0, 0, 0));
      press_start();
      chk("run_entered", 23'(bus.oRUN), 23'd1);
      chk("no_tick_yet", 23'(bus.oTICK), 23'd0);
      step(3);
      chk("first_tick", 23'(bus.oTICK), 23'd1);
      chk("pre_borrow", cur(), tv(1, 0, 0, 0, 0, 0));
      step(1);
      chk("borrow_chain", cur(), tv(0, 5, 9, 5, 9, 9));
      chk("tick_low", 23'(bus.oTICK), 23'd0);
      step(4);
      chk("second_dec", cur(), tv(0, 5, 9, 5, 9, 8));

      #2 rst_n = 1'b0;
      #1;
      chk("async_digits", cur(), tv(0, 0, 0, 0, 0, 0));
      chk("async_run", 23'(bus.oRUN), 23'd0);
      chk("async_done", 23'(bus.oDONE), 23'd0);
      step(1);
      rst_n = 1'b1;
      step(2);

      press_start();
      chk("zero_start_idle", 23'(bus.oRUN), 23'd0);
      step(4);
      chk("zero_still_idle", 23'(bus.oRUN), 23'd0);

      load(0, 2);
      press_start();
      step(3);
      chk("c_tick1", 23'(bus.oTICK), 23'd1);
      step(1);
      chk("c_dec1", cur(), tv(0, 0, 0, 0, 0, 1));
      step(3);
      chk("c_tick2", 23'(bus.oTICK), 23'd1);
      chk("c_run_last", 23'(bus.oRUN), 23'd1);
      step(1);
      chk("c_zero", cur(), tv(0, 0, 0, 0, 0, 0));
      chk("c_done", 23'(bus.oDONE), 23'd1);
      chk("c_run_off", 23'(bus.oRUN), 23'd0);
      chk("c_tick_off", 23'(bus.oTICK), 23'd0);
      step(5);
      chk("c_done_held", 23'(bus.oDONE), 23'd1);
      chk("c_tick_quiet", 23'(bus.oTICK), 23'd0);
      press_start();
      chk("c_ack_done", 23'(bus.oDONE), 23'd0);
      chk("c_ack_run", 23'(bus.oRUN), 23'd0);

      load(0, 5);
      press_start();
      step(6);
      chk("p_before", cur(), tv(0, 0, 0, 0, 0, 4));
      press_start();
      chk("p_paused", 23'(bus.oRUN), 23'd0);
      chk("p_value", cur(), tv(0, 0, 0, 0, 0, 3));
      step(5);
      chk("p_frozen", cur(), tv(0, 0, 0, 0, 0, 3));
      chk("p_no_tick", 23'(bus.oTICK), 23'd0);
      press_start();
      chk("p_resumed", 23'(bus.oRUN), 23'd1);
      step(2);
      chk("p_phase_tick", 23'(bus.oTICK), 23'd1);
      step(1);
      chk("p_phase_dec", cur(), tv(0, 0, 0, 0, 0, 2));
      load(0, 9);
      chk("run_load_ign", cur(), tv(0, 0, 0, 0, 0, 1));
      step(4);
      chk("p_done", 23'(bus.oDONE), 23'd1);
      load(1, 7);
      chk("done_load_val", cur(), tv(0, 0, 0, 0, 7, 0));
      chk("done_load_idle", 23'(bus.oDONE), 23'd0);

      press_start();
      press_start();
      chk("s_paused", 23'(bus.oRUN), 23'd0);
      chk("s_value", cur(), tv(0, 0, 0, 0, 7, 0));
      bus.iSEL    = 3'd0;
      bus.iDATA   = 5'd4;
      bus.iSTARTn = 1'b0;
      bus.iLOADn  = 1'b0;
      step(1);
      bus.iSTARTn = 1'b1;
      bus.iLOADn  = 1'b1;
      step(3);
      chk("s_run", 23'(bus.oRUN), 23'd1);
      chk("s_no_load", cur(), tv(0, 0, 0, 0, 7, 0));
      chk("s_held_tick", 23'(bus.oTICK), 23'd1);
      step(1);
      chk("s_dec", cur(), tv(0, 0, 0, 0, 6, 9));

      bus.iSTARTn = 1'b0;
      step(50);
      bus.iSTARTn = 1'b1;
      step(3);
      chk("hold_one_toggle", 23'(bus.oRUN), 23'd0);
      chk("hold_value", cur(), tv(0, 0, 0, 0, 6, 9));
      step(8);
      chk("hold_frozen", cur(), tv(0, 0, 0, 0, 6, 9));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
